// File: rtl/wb_mem_responder.sv
// Wishbone classic responder for the user-project BRAM, serving cpu and dma initiators.
// Define WB_RESP_RR_EN for round-robin arbitration; otherwise dma has fixed priority.
module wb_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h3800_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic        cpu_ack_o,
    output logic [31:0] cpu_dat_o,
    input  logic        dma_cyc_i,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_sel_i,
    input  logic [31:0] dma_adr_i,
    input  logic [31:0] dma_dat_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_dat_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
    localparam logic [31-AW-2:0] BASE_TAG = ADDR_BASE[31:AW+2];

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_dma_q, gnt_dma_d;
    logic [29:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cpu_dat_q, cpu_dat_d;
    logic [31:0] dma_dat_q, dma_dat_d;

    logic        cpu_req, dma_req, pick_dma;
    logic [29:0] in_adr, cur_adr;
    logic        in_we, cur_we, cur_dma;
    logic [3:0]  in_sel, cur_sel;
    logic [31:0] in_dat, cur_dat;
    logic        gnt_cyc, enter_ack, hit, mem_we;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic        unused_lsb;

    logic [31:0] mem [DEPTH_WORDS];

    assign unused_lsb = ^{cpu_adr_i[1:0], dma_adr_i[1:0]};
    assign cpu_req = cpu_cyc_i & cpu_stb_i;
    assign dma_req = dma_cyc_i & dma_stb_i;

`ifdef WB_RESP_RR_EN
    logic prio_dma_q, prio_dma_d;
    assign pick_dma = dma_req & (~cpu_req | prio_dma_q);
`else
    assign pick_dma = dma_req;
`endif

    assign in_adr = pick_dma ? dma_adr_i[31:2] : cpu_adr_i[31:2];
    assign in_we  = pick_dma ? dma_we_i  : cpu_we_i;
    assign in_sel = pick_dma ? dma_sel_i : cpu_sel_i;
    assign in_dat = pick_dma ? dma_dat_i : cpu_dat_i;

    // In IDLE the live inputs stand in for the registers so LAT=0 works.
    assign cur_adr = (state_q == IDLE) ? in_adr   : adr_q;
    assign cur_we  = (state_q == IDLE) ? in_we    : we_q;
    assign cur_sel = (state_q == IDLE) ? in_sel   : sel_q;
    assign cur_dat = (state_q == IDLE) ? in_dat   : wdat_q;
    assign cur_dma = (state_q == IDLE) ? pick_dma : gnt_dma_q;

    assign hit     = (cur_adr[29:AW] == BASE_TAG);
    assign idx     = cur_adr[AW-1:0];
    assign rd_word = hit ? mem[idx] : 32'h0;
    assign gnt_cyc = gnt_dma_q ? dma_cyc_i : cpu_cyc_i;

    always_comb begin
        state_d   = state_q;
        gnt_dma_d = gnt_dma_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
`ifdef WB_RESP_RR_EN
        prio_dma_d = prio_dma_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req | dma_req) begin
                    gnt_dma_d = pick_dma;
                    adr_d     = in_adr;
                    we_d      = in_we;
                    sel_d     = in_sel;
                    wdat_d    = in_dat;
                    cnt_d     = CNT_INIT;
`ifdef WB_RESP_RR_EN
                    prio_dma_d = ~pick_dma;
`endif
                    if (LAT == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_dat_d = cpu_dat_q;
        dma_dat_d = dma_dat_q;
        if (enter_ack && !cur_we) begin
            if (cur_dma) dma_dat_d = rd_word;
            else         cpu_dat_d = rd_word;
        end
    end

    assign mem_we = enter_ack & cur_we & hit & ~wb_rst_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gnt_dma_q <= 1'b0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
            cnt_q     <= '0;
            cpu_dat_q <= '0;
            dma_dat_q <= '0;
`ifdef WB_RESP_RR_EN
            prio_dma_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_dma_q <= gnt_dma_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            cnt_q     <= cnt_d;
            cpu_dat_q <= cpu_dat_d;
            dma_dat_q <= dma_dat_d;
`ifdef WB_RESP_RR_EN
            prio_dma_q <= prio_dma_d;
`endif
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
            end
        end
    end

    assign cpu_ack_o = (state_q == ACK) & ~gnt_dma_q;
    assign dma_ack_o = (state_q == ACK) &  gnt_dma_q;
    assign cpu_dat_o = cpu_dat_q;
    assign dma_dat_o = dma_dat_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed and randomized bench for wb_mem_responder against a word-array reference model.
module tb_wb_mem_responder;

    localparam logic [31:0] BASE  = 32'h3800_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;

    logic        clk, rst;
    logic        cpu_cyc, cpu_stb, cpu_we, cpu_ack;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_adr, cpu_wdat, cpu_rdat;
    logic        dma_cyc, dma_stb, dma_we, dma_ack;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_wdat, dma_rdat;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [int];
    bit last_dma = 1'b1;

    wb_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we),
        .cpu_sel_i(cpu_sel), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_wdat),
        .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_rdat),
        .dma_cyc_i(dma_cyc), .dma_stb_i(dma_stb), .dma_we_i(dma_we),
        .dma_sel_i(dma_sel), .dma_adr_i(dma_adr), .dma_dat_i(dma_wdat),
        .dma_ack_o(dma_ack), .dma_dat_o(dma_rdat),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < DEPTH * 4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        if (!in_win(a)) return 32'h0;
        if (!mdl.exists(widx(a))) return 32'hx;
        return mdl[widx(a)];
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] w;
        if (!in_win(a)) return;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[widx(a)] = w;
    endtask

    task automatic idle_all();
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = 0; cpu_adr = 0; cpu_wdat = 0;
        dma_cyc = 0; dma_stb = 0; dma_we = 0; dma_sel = 0; dma_adr = 0; dma_wdat = 0;
    endtask

    task automatic drive(input bit d, input bit we, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d) begin
            dma_cyc = 1; dma_stb = 1; dma_we = we; dma_sel = s; dma_adr = a; dma_wdat = wd;
        end else begin
            cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_sel = s; cpu_adr = a; cpu_wdat = wd;
        end
    endtask

    task automatic release_port(input bit d);
        if (d) begin dma_cyc = 0; dma_stb = 0; end
        else begin cpu_cyc = 0; cpu_stb = 0; end
    endtask

    task automatic txn(input string tag, input bit d, input bit we, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
        int n;
        bit got;
        logic [31:0] other_dat, exp;
        @(posedge clk); #1;
        other_dat = d ? cpu_rdat : dma_rdat;
        exp = mdl_rd(a);
        drive(d, we, s, a, wd);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (d ? dma_ack : cpu_ack) got = 1;
        end
        check({tag, "_acked"}, 32'(got), 32'd1);
        check({tag, "_lat"}, n, LAT + 1);
        check({tag, "_other_ack"}, 32'(d ? cpu_ack : dma_ack), 32'd0);
        check({tag, "_other_dat"}, d ? cpu_rdat : dma_rdat, other_dat);
        if (!we && !$isunknown(exp)) check({tag, "_rdata"}, d ? dma_rdat : cpu_rdat, exp);
        release_port(d);
        last_dma = d;
        if (we) mdl_wr(a, s, wd);
    endtask

    initial begin
        int n;
        bit got, exp_dma, was_dma;
        logic [31:0] a;
        idle_all();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        check("rst_cpu_dat", cpu_rdat, 32'd0);
        check("rst_dma_dat", dma_rdat, 32'd0);
        rst = 0;
        @(posedge clk); #1;
        check("rel_acks", 32'(cpu_ack | dma_ack), 32'd0);

        txn("cpu_wr", 0, 1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
        txn("cpu_rd", 0, 0, 4'hF, 32'h3800_0010, 32'h0);
        check("cpu_rd_val", cpu_rdat, 32'hDEAD_BEEF);

        txn("bl_pre", 0, 1, 4'hF, 32'h3800_0020, 32'h1122_3344);
        txn("bl_wr", 0, 1, 4'b0101, 32'h3800_0020, 32'hAABB_CCDD);
        txn("bl_rd", 1, 0, 4'hF, 32'h3800_0020, 32'h0);
        check("bl_val", dma_rdat, 32'h11BB_33DD);

        txn("sel0_wr", 1, 1, 4'h0, 32'h3800_0020, 32'h5555_5555);
        txn("sel0_rd", 0, 0, 4'hF, 32'h3800_0020, 32'h0);

        for (int k = 0; k < 11; k++)
            txn("pre", k[0], 1, 4'hF, BASE + 32'h100 + 32'(4 * k), $urandom);

        @(posedge clk); #1;
        a = BASE + 32'h100;
        drive(1, 0, 4'hF, a, 32'h0);
        for (int k = 0; k < 11; k++) begin
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clk); #1; n++;
                if (dma_ack) got = 1;
            end
            check("strm_acked", 32'(got), 32'd1);
            check("strm_gap", n, (k == 0) ? LAT + 1 : LAT + 2);
            check("strm_data", dma_rdat, mdl_rd(a));
            check("strm_cpu_ack", 32'(cpu_ack), 32'd0);
            a = a + 4;
            dma_adr = a;
        end
        release_port(1);
        last_dma = 1;

        txn("oow_rd", 0, 0, 4'hF, 32'h3000_0000, 32'h0);
        check("oow_rd_zero", cpu_rdat, 32'h0);
        txn("oow_wr", 1, 1, 4'hF, 32'h3000_0010, 32'h0BAD_F00D);
        txn("oow_chk", 0, 0, 4'hF, 32'h3800_0010, 32'h0);
        check("oow_unchanged", cpu_rdat, 32'hDEAD_BEEF);

        // Both initiators hold requests; the model picks by the rules.
        @(posedge clk); #1;
        drive(0, 0, 4'hF, 32'h3800_0010, 32'h0);
        drive(1, 0, 4'hF, 32'h3800_0020, 32'h0);
        for (int k = 0; k < 5; k++) begin
`ifdef WB_RESP_RR_EN
            exp_dma = (k == 4) ? 1'b0 : ~last_dma;
`else
            exp_dma = (k != 4);
`endif
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clk); #1; n++;
                if (cpu_ack | dma_ack) got = 1;
            end
            was_dma = dma_ack;
            check("arb_acked", 32'(got), 32'd1);
            check("arb_single", 32'(cpu_ack & dma_ack), 32'd0);
            check("arb_port", 32'(was_dma), 32'(exp_dma));
            check("arb_data", was_dma ? dma_rdat : cpu_rdat,
                  was_dma ? 32'h11BB_33DD : 32'hDEAD_BEEF);
            last_dma = was_dma;
            if (k == 3) release_port(1);
        end
        release_port(0);

        @(posedge clk); #1;
        drive(1, 1, 4'hF, 32'h3800_0020, $urandom);
        @(posedge clk); #1;
        dma_cyc = 0; dma_stb = 0;
        last_dma = 1;
        got = 0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (dma_ack | cpu_ack) got = 1;
        end
        check("abort_noack", 32'(got), 32'd0);
        txn("abort_rd", 0, 0, 4'hF, 32'h3800_0020, 32'h0);
        check("abort_unchanged", cpu_rdat, 32'h11BB_33DD);

        @(posedge clk); #1;
        drive(0, 1, 4'hF, 32'h3800_0010, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1;
        idle_all();
        @(posedge clk); #1;
        check("rstb_busy", 32'(busy), 32'd0);
        check("rstb_cpu_dat", cpu_rdat, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        last_dma = 1;
        got = 0;
        repeat (LAT + 4) begin
            if (cpu_ack | dma_ack) got = 1;
            @(posedge clk); #1;
        end
        check("rstb_noack", 32'(got), 32'd0);
        txn("rstb_rd", 1, 0, 4'hF, 32'h3800_0010, 32'h0);
        check("rstb_unchanged", dma_rdat, 32'hDEAD_BEEF);

        for (int k = 0; k < 12; k++) begin
            logic [31:0] ra;
            ra = BASE + 32'h100 + 32'(4 * $urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) ra = ra ^ 32'h0100_0000;
            txn("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), ra, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
